player_input_checker: RTL and testbench

//  Consumer side of the game sequence. The controller writes each round's colour sequence into
//  the sequence memory and plays it back; this block reads the same memory back and captures

---
 rtl/player_input_checker_pkg.sv | 26 ++
 rtl/player_input_checker_if.sv | 47 ++++
 rtl/player_input_checker_button_press_detect.sv | 50 +++++
 rtl/player_input_checker.sv | 166 ++++++++++++++++
 tb/tb_player_input_checker.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/player_input_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : player_input_checker_pkg
// Brief    : Shared constants and types for the player input checker and the
//            game controller that fills the sequence memory.
// Revision : 1.0 - initial release
// ============================================================================
package player_input_checker_pkg;

    localparam int MAX_LEN     = 32;
    localparam int NUM_BUTTONS = 4;
    localparam int COLOR_W     = $clog2(NUM_BUTTONS);

    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_WAIT_DATA  = 3'd2,
        ST_WAIT_PRESS = 3'd3,
        ST_COMPARE    = 3'd4,
        ST_REPORT     = 3'd5
    } checker_state_t;

endpackage : player_input_checker_pkg
`default_nettype wire

// File: rtl/player_input_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : player_input_checker_if
// Brief    : Controller handshake, sequence-memory read port and button levels
//            of the player input checker.
// Revision : 1.0 - initial release
// ============================================================================
interface player_input_checker_if #(
    parameter int MAX_LEN     = player_input_checker_pkg::MAX_LEN,
    parameter int NUM_BUTTONS = player_input_checker_pkg::NUM_BUTTONS
);
    import player_input_checker_pkg::*;

    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int CODE_W = $clog2(NUM_BUTTONS);

    logic                   start;
    logic [ADDR_W:0]        round_len;
    logic [NUM_BUTTONS-1:0] buttons;
    logic                   mem_rd;
    logic [ADDR_W-1:0]      mem_addr;
    logic [CODE_W-1:0]      mem_rdata;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic                   fail;
    logic                   timeout;
    logic                   press_valid;
    logic [CODE_W-1:0]      press_color;
    logic [ADDR_W:0]        cur_index;

    // Controller / memory / button side
    modport master (
        output start, round_len, buttons, mem_rdata,
        input  mem_rd, mem_addr, busy, done, pass, fail, timeout,
               press_valid, press_color, cur_index
    );

    // Checker side
    modport slave (
        input  start, round_len, buttons, mem_rdata,
        output mem_rd, mem_addr, busy, done, pass, fail, timeout,
               press_valid, press_color, cur_index
    );

endinterface : player_input_checker_if
`default_nettype wire

// File: rtl/player_input_checker_button_press_detect.sv
`default_nettype none
// ============================================================================
// Module   : player_input_checker_button_press_detect
// Brief    : Turns button levels into single press events: exactly one button
//            down after a cycle with none down. Also encodes the colour.
// Revision : 1.0 - initial release
// ============================================================================
module player_input_checker_button_press_detect #(
    parameter  int NUM_BUTTONS = player_input_checker_pkg::NUM_BUTTONS,
    localparam int CODE_W      = $clog2(NUM_BUTTONS)
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic                   press_pulse,
    output logic [CODE_W-1:0]      press_code
);
    import player_input_checker_pkg::*;

    logic [NUM_BUTTONS-1:0] buttons_q;
    logic [NUM_BUTTONS-1:0] buttons_d;
    logic                   w_one_hot;

    always_comb begin
        buttons_d = buttons;
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            buttons_q <= '0;
        end else begin
            buttons_q <= buttons_d;
        end
    end

    assign w_one_hot   = (buttons != '0) && ((buttons & (buttons - 1'b1)) == '0);
    assign press_pulse = w_one_hot && (buttons_q == '0);

    // Encoding is only meaningful when w_one_hot is set
    always_comb begin
        press_code = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (buttons[i]) begin
                press_code = CODE_W'(i);
            end
        end
    end

endmodule : player_input_checker_button_press_detect
`default_nettype wire

// File: rtl/player_input_checker.sv
`default_nettype none
// ============================================================================
// Module   : player_input_checker
// Brief    : Reads the stored colour sequence back and checks the player's
//            presses against it in order; reports pass/fail/timeout.
// Revision : 1.0 - initial release
// ============================================================================
module player_input_checker #(
    parameter int MAX_LEN        = player_input_checker_pkg::MAX_LEN,
    parameter int NUM_BUTTONS    = player_input_checker_pkg::NUM_BUTTONS,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst_,
    player_input_checker_if.slave bus
);
    import player_input_checker_pkg::*;

    localparam int ADDR_W  = $clog2(MAX_LEN);
    localparam int IDX_W   = ADDR_W + 1;
    localparam int CODE_W  = $clog2(NUM_BUTTONS);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]   LEN_MAX    = IDX_W'(MAX_LEN);

    checker_state_t      state_q,       state_d;
    logic [IDX_W-1:0]    index_q,       index_d;
    logic [IDX_W-1:0]    len_q,         len_d;
    logic [CODE_W-1:0]   expected_q,    expected_d;
    logic [TIMER_W-1:0]  timer_q,       timer_d;
    logic                pass_q,        pass_d;
    logic                fail_q,        fail_d;
    logic                timeout_q,     timeout_d;
    logic                press_valid_q, press_valid_d;
    logic [CODE_W-1:0]   press_color_q, press_color_d;

    logic                w_press_pulse;
    logic [CODE_W-1:0]   w_press_code;
    logic [IDX_W-1:0]    w_index_inc;

    function automatic logic len_ok(input logic [IDX_W-1:0] len);
        return (len != '0) && (len <= LEN_MAX);
    endfunction

    player_input_checker_button_press_detect #(
        .NUM_BUTTONS (NUM_BUTTONS)
    ) u_press_detect (
        .clk         (clk),
        .rst_        (rst_),
        .buttons     (bus.buttons),
        .press_pulse (w_press_pulse),
        .press_code  (w_press_code)
    );

    assign w_index_inc = index_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        len_d         = len_q;
        expected_d    = expected_q;
        timer_d       = timer_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timeout_d     = timeout_q;
        press_valid_d = 1'b0;
        press_color_d = press_color_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                    index_d   = '0;
                    len_d     = bus.round_len;
                    // Illegal lengths still pass through COMPARE so the
                    // result appears two cycles after start, as for a press.
                    state_d   = len_ok(bus.round_len) ? ST_FETCH : ST_COMPARE;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                expected_d = bus.mem_rdata;
                timer_d    = '0;
                state_d    = ST_WAIT_PRESS;
            end
            ST_WAIT_PRESS: begin
                if (w_press_pulse) begin
                    press_color_d = w_press_code;
                    press_valid_d = 1'b1;
                    state_d       = ST_COMPARE;
                end else if (timer_q == TIMER_LAST) begin
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_REPORT;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_COMPARE: begin
                if (!len_ok(len_q) || (press_color_q != expected_q)) begin
                    fail_d  = 1'b1;
                    state_d = ST_REPORT;
                end else begin
                    index_d = w_index_inc;
                    if (w_index_inc == len_q) begin
                        pass_d  = 1'b1;
                        state_d = ST_REPORT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q       <= ST_IDLE;
            index_q       <= '0;
            len_q         <= '0;
            expected_q    <= '0;
            timer_q       <= '0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            press_valid_q <= 1'b0;
            press_color_q <= '0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            len_q         <= len_d;
            expected_q    <= expected_d;
            timer_q       <= timer_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
            press_valid_q <= press_valid_d;
            press_color_q <= press_color_d;
        end
    end

    assign bus.mem_rd      = (state_q == ST_FETCH);
    assign bus.mem_addr    = bus.mem_rd ? index_q[ADDR_W-1:0] : '0;
    assign bus.busy        = (state_q == ST_FETCH)      || (state_q == ST_WAIT_DATA) ||
                             (state_q == ST_WAIT_PRESS) || (state_q == ST_COMPARE);
    assign bus.done        = (state_q == ST_REPORT);
    assign bus.pass        = pass_q;
    assign bus.fail        = fail_q;
    assign bus.timeout     = timeout_q;
    assign bus.press_valid = press_valid_q;
    assign bus.press_color = press_color_q;
    assign bus.cur_index   = index_q;

endmodule : player_input_checker
`default_nettype wire

// File: tb/tb_player_input_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_input_checker
// Brief    : Randomised rounds against a cycle-count model of the checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_input_checker;
    import player_input_checker_pkg::*;

    localparam int T  = 16;
    localparam int ML = MAX_LEN;
    localparam int NB = NUM_BUTTONS;
    localparam int AW = $clog2(ML);
    localparam int IW = AW + 1;
    localparam int CW = $clog2(NB);

    logic clk  = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    player_input_checker_if #(.MAX_LEN(ML), .NUM_BUTTONS(NB)) bus ();

    player_input_checker #(
        .MAX_LEN        (ML),
        .NUM_BUTTONS    (NB),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    color_t mem [ML];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc   = 0;

    // Sequence memory: data valid the cycle after the read strobe, noise otherwise
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_rd ? mem[bus.mem_addr] : CW'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        bus.start = 1'b0;
    endtask

    function automatic logic [NB-1:0] onehot(input color_t c);
        return NB'(1) << c;
    endfunction

    function automatic logic [NB-1:0] two_hot();
        int a;
        int b;
        a = $urandom_range(0, NB - 1);
        b = (a + 1 + $urandom_range(0, NB - 2)) % NB;
        return (NB'(1) << a) | (NB'(1) << b);
    endfunction

    task automatic chk_wait(input string tag);
        chk({tag, "/mem_rd"},      32'(bus.mem_rd),      0);
        chk({tag, "/done"},        32'(bus.done),        0);
        chk({tag, "/press_valid"}, 32'(bus.press_valid), 0);
        chk({tag, "/busy"},        32'(bus.busy),        1);
    endtask

    task automatic chk_result(input string tag, input int p, input int f, input int t, input int idx);
        chk({tag, "/done"},      32'(bus.done),      1);
        chk({tag, "/busy"},      32'(bus.busy),      0);
        chk({tag, "/mem_rd"},    32'(bus.mem_rd),    0);
        chk({tag, "/pass"},      32'(bus.pass),      32'(p));
        chk({tag, "/fail"},      32'(bus.fail),      32'(f));
        chk({tag, "/timeout"},   32'(bus.timeout),   32'(t));
        chk({tag, "/cur_index"}, 32'(bus.cur_index), 32'(idx));
    endtask

    task automatic finish_round(input int rel, input logic [NB-1:0] hold);
        while (cyc < rel) begin
            tick();
            bus.buttons = (cyc < rel) ? hold : '0;
        end
        tick();
        bus.buttons = '0;
        chk("end/done_low", 32'(bus.done), 0);
        chk("end/busy_low", 32'(bus.busy), 0);
    endtask

    // One round. wrong_step / to_step: step index that gets a wrong colour /
    // no press at all (-1 for none). noise adds rejected multi-button presses,
    // long holds into the next wait and stray start pulses while busy.
    task automatic run_round(input int len, input bit rnd_mem, input int wrong_step,
                             input int to_step, input bit noise);
        int              idx;
        int              f;
        int              p;
        int              k;
        int              kmin;
        int              rel;
        bit              glitch;
        bit              tmo;
        color_t          col;
        logic [NB-1:0]   hold;

        if (rnd_mem) begin
            for (int i = 0; i < ML; i++) mem[i] = CW'($urandom);
        end
        bus.round_len = IW'(len);
        bus.start     = 1'b1;
        tick();
        if (len < 1 || len > ML) begin
            chk("badlen/busy",   32'(bus.busy),   1);
            chk("badlen/mem_rd", 32'(bus.mem_rd), 0);
            chk("badlen/done",   32'(bus.done),   0);
            tick();
            chk_result("badlen", 0, 1, 0, 0);
            finish_round(0, '0);
            return;
        end

        idx  = 0;
        rel  = 0;
        hold = '0;
        f    = cyc;
        while (1) begin
            chk("fetch/mem_rd",    32'(bus.mem_rd),    1);
            chk("fetch/mem_addr",  32'(bus.mem_addr),  32'(idx));
            chk("fetch/cur_index", 32'(bus.cur_index), 32'(idx));
            chk("fetch/busy",      32'(bus.busy),      1);

            tmo    = (idx == to_step);
            col    = (idx == wrong_step) ? CW'(mem[idx] + 1 + $urandom_range(0, 2)) : mem[idx];
            glitch = noise && ($urandom_range(0, 2) == 0);
            // Earliest legal press: after release (and after the glitch gap)
            kmin = rel + (glitch ? 2 : 1) - (f + 2);
            if (kmin < 0) kmin = 0;
            k = ($urandom_range(0, 5) == 0) ? T - 1 : kmin + $urandom_range(0, 4);
            p = f + 2 + k;

            while (1) begin
                tick();
                bus.buttons = (cyc < rel) ? hold : '0;
                if (glitch && cyc == p - 2) bus.buttons = two_hot();
                if (!tmo && cyc == p) bus.buttons = onehot(col);
                if (noise && cyc >= f + 2 && $urandom_range(0, 9) == 0) begin
                    bus.start     = 1'b1;
                    bus.round_len = IW'($urandom_range(0, ML));
                end
                if (tmo && cyc == f + 2 + T) begin
                    chk_result("timeout", 0, 1, 1, idx);
                    finish_round(rel, hold);
                    return;
                end
                chk_wait("wait");
                if (!tmo && cyc == p) break;
            end

            hold = onehot(col);
            rel  = p + $urandom_range(1, noise ? 5 : 2);
            tick();
            bus.buttons = (cyc < rel) ? hold : '0;
            chk("cmp/press_valid", 32'(bus.press_valid), 1);
            chk("cmp/press_color", 32'(bus.press_color), 32'(col));
            chk("cmp/busy",        32'(bus.busy),        1);
            chk("cmp/mem_rd",      32'(bus.mem_rd),      0);
            tick();
            bus.buttons = (cyc < rel) ? hold : '0;
            if (col != mem[idx]) begin
                chk_result("wrong", 0, 1, 0, idx);
                finish_round(rel, hold);
                return;
            end
            idx++;
            if (idx == len) begin
                chk_result("pass", 1, 0, 0, len);
                finish_round(rel, hold);
                return;
            end
            f = cyc;
        end
    endtask

    task automatic run_reset_test();
        int seen;
        for (int i = 0; i < ML; i++) mem[i] = CW'($urandom);
        mem[0]        = CW'(3);
        bus.round_len = IW'(3);
        bus.start     = 1'b1;
        tick();
        chk("rst/fetch", 32'(bus.mem_rd), 1);
        tick();
        tick();
        bus.buttons = onehot(mem[0]);
        tick();
        bus.buttons = '0;
        chk("rst/press_valid", 32'(bus.press_valid), 1);
        tick();
        tick();
        tick();
        chk("rst/pre_idx",  32'(bus.cur_index), 1);
        chk("rst/pre_busy", 32'(bus.busy),      1);
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
        chk("rst/busy",        32'(bus.busy),        0);
        chk("rst/done",        32'(bus.done),        0);
        chk("rst/pass",        32'(bus.pass),        0);
        chk("rst/fail",        32'(bus.fail),        0);
        chk("rst/timeout",     32'(bus.timeout),     0);
        chk("rst/press_valid", 32'(bus.press_valid), 0);
        chk("rst/press_color", 32'(bus.press_color), 0);
        chk("rst/cur_index",   32'(bus.cur_index),   0);
        chk("rst/mem_rd",      32'(bus.mem_rd),      0);
        chk("rst/mem_addr",    32'(bus.mem_addr),    0);
        seen = 0;
        repeat (20) begin
            tick();
            if (bus.done || bus.busy) seen++;
        end
        chk("rst/no_done", 32'(seen), 0);
    endtask

    initial begin
        int len;
        int wrong;
        int to;
        bus.start     = 1'b0;
        bus.round_len = '0;
        bus.buttons   = '0;
        repeat (3) tick();
        rst_ = 1'b1;
        tick();
        chk("init/busy",      32'(bus.busy),      0);
        chk("init/done",      32'(bus.done),      0);
        chk("init/pass",      32'(bus.pass),      0);
        chk("init/fail",      32'(bus.fail),      0);
        chk("init/timeout",   32'(bus.timeout),   0);
        chk("init/mem_rd",    32'(bus.mem_rd),    0);
        chk("init/cur_index", 32'(bus.cur_index), 0);

        mem[0] = CW'(2); mem[1] = CW'(0); mem[2] = CW'(3);
        run_round(3, 1'b0, -1, -1, 1'b0);
        mem[0] = CW'(1); mem[1] = CW'(1);
        run_round(2, 1'b0, 1, -1, 1'b0);
        run_round(4, 1'b1, -1, -1, 1'b1);
        run_round(2, 1'b1, -1, 0, 1'b0);
        run_round(3, 1'b1, -1, 2, 1'b1);
        run_round(0, 1'b1, -1, -1, 1'b0);
        run_round(ML + 1, 1'b1, -1, -1, 1'b0);
        run_round(ML, 1'b1, -1, -1, 1'b0);

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 9) == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(ML + 1, (1 << IW) - 1);
            end else begin
                len = $urandom_range(1, 10);
            end
            wrong = ($urandom_range(0, 2) == 0 && len > 0) ? $urandom_range(0, len - 1) : -1;
            to    = ($urandom_range(0, 4) == 0 && len > 0) ? $urandom_range(0, len - 1) : -1;
            run_round(len, 1'b1, wrong, to, 1'b1);
        end

        run_reset_test();
        run_round(2, 1'b1, -1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_player_input_checker
`default_nettype wire
